// File: rtl/step_ramp_generator.sv
// Avalon-MM programmed trapezoidal step/direction generator for a stepper driver.
// Define STEP_RAMP_POSITION_EN to build the signed POSITION counter at address 7.
module step_ramp_generator #(
    parameter int CNT_W      = 32,
    parameter int PULSE_W    = 16,
    parameter int MIN_PERIOD = 64
) (
    input  logic        csi_MCLK_clk,
    input  logic        rsi_MRST_reset,
    input  logic [31:0] avs_ctrl_writedata,
    output logic [31:0] avs_ctrl_readdata,
    input  logic [3:0]  avs_ctrl_byteenable,
    input  logic [2:0]  avs_ctrl_address,
    input  logic        avs_ctrl_write,
    input  logic        avs_ctrl_read,
    output logic        avs_ctrl_waitrequest,
    output logic        coe_step,
    output logic        coe_dir,
    output logic        coe_busy,
    output logic        ins_irq
);

    localparam int PW_W = $clog2(PULSE_W + 1);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] MIN_P   = CNT_W'(MIN_PERIOD);
    localparam logic [PW_W-1:0]  PW_LOAD = PW_W'(PULSE_W - 1);
    localparam logic [PW_W-1:0]  PW_ONE  = PW_W'(1);

    typedef enum logic [1:0] {S_IDLE, S_ACCEL, S_CRUISE, S_DECEL} state_t;

    function automatic logic [31:0] be_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  be);
        logic [31:0] res;
        res = old_v;
        for (int i = 0; i < 4; i++)
            if (be[i]) res[8*i +: 8] = new_v[8*i +: 8];
        return res;
    endfunction

    function automatic logic [CNT_W-1:0] floor_period(input logic [CNT_W-1:0] v);
        return (v < MIN_P) ? MIN_P : v;
    endfunction

    // Both saturating helpers assume lo <= v <= hi, so the differences never wrap.
    function automatic logic [CNT_W-1:0] sat_sub(input logic [CNT_W-1:0] v,
                                                 input logic [CNT_W-1:0] d,
                                                 input logic [CNT_W-1:0] lo);
        return ((v - lo) <= d) ? lo : (v - d);
    endfunction

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] v,
                                                 input logic [CNT_W-1:0] d,
                                                 input logic [CNT_W-1:0] hi);
        return ((hi - v) <= d) ? hi : (v + d);
    endfunction

    logic [31:0] r_steps, r_start_p, r_end_p, r_accel;
    logic        r_ctrl_dir, r_irq_en, r_done;

    logic [CNT_W-1:0] r_sh_start, r_sh_end, r_sh_accel;
    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cur, r_ramp, r_rem, r_cnt;
    logic [CNT_W-1:0] w_cur_nxt, w_ramp_nxt, w_rem_nxt, w_cnt_nxt, w_rem_dec;
    logic [PW_W-1:0]  r_pw, w_pw_nxt;
    logic             r_step, r_dir, r_busy, r_last, r_stop_pend;
    logic             w_step_nxt, w_dir_nxt, w_busy_nxt, w_last_nxt, w_stop_nxt;
    logic             w_load, w_done_set, w_falling;

    logic w_wr_ctrl, w_start_req, w_stop_req, w_done_clr;
    assign w_wr_ctrl   = avs_ctrl_write && (avs_ctrl_address == 3'd4) && avs_ctrl_byteenable[0];
    assign w_start_req = w_wr_ctrl && avs_ctrl_writedata[1];
    assign w_stop_req  = w_wr_ctrl && avs_ctrl_writedata[2];
    assign w_done_clr  = avs_ctrl_write && (avs_ctrl_address == 3'd5) &&
                         avs_ctrl_byteenable[0] && avs_ctrl_writedata[1];

    logic [CNT_W-1:0] w_steps_c, w_accel_c, w_eff_start, w_eff_end_raw, w_eff_end;
    assign w_steps_c     = CNT_W'(r_steps);
    assign w_accel_c     = CNT_W'(r_accel);
    assign w_eff_start   = floor_period(CNT_W'(r_start_p));
    assign w_eff_end_raw = floor_period(CNT_W'(r_end_p));
    // An end period slower than the start period collapses to a constant-speed move.
    assign w_eff_end     = (w_eff_end_raw > w_eff_start) ? w_eff_start : w_eff_end_raw;

    always_comb begin
        w_state_nxt = r_state;
        w_cur_nxt   = r_cur;
        w_ramp_nxt  = r_ramp;
        w_rem_nxt   = r_rem;
        w_cnt_nxt   = r_cnt;
        w_pw_nxt    = r_pw;
        w_step_nxt  = r_step;
        w_dir_nxt   = r_dir;
        w_busy_nxt  = r_busy;
        w_last_nxt  = r_last;
        w_stop_nxt  = r_stop_pend;
        w_load      = 1'b0;
        w_done_set  = 1'b0;
        w_rem_dec   = r_rem - ONE;
        w_falling   = r_step && (r_pw == '0);
        if (r_state == S_IDLE) begin
            if (w_start_req) begin
                w_load    = 1'b1;
                w_dir_nxt = avs_ctrl_writedata[0];
                w_rem_nxt = w_steps_c;
                if (w_steps_c == '0) begin
                    w_done_set = 1'b1;
                end else begin
                    w_state_nxt = (w_accel_c == '0) ? S_CRUISE : S_ACCEL;
                    w_busy_nxt  = 1'b1;
                    w_cur_nxt   = w_eff_start;
                    w_ramp_nxt  = '0;
                    w_cnt_nxt   = w_eff_start - ONE;
                    w_last_nxt  = 1'b0;
                    w_stop_nxt  = 1'b0;
                end
            end
        end else if ((w_falling && (r_last || r_stop_pend || w_stop_req)) ||
                     (!r_step && w_stop_req)) begin
            // Move ends on the falling edge of the final (or interrupted) pulse.
            w_state_nxt = S_IDLE;
            w_busy_nxt  = 1'b0;
            w_step_nxt  = 1'b0;
            w_last_nxt  = 1'b0;
            w_stop_nxt  = 1'b0;
            w_done_set  = 1'b1;
        end else begin
            if (r_step) begin
                if (w_falling) w_step_nxt = 1'b0;
                else           w_pw_nxt   = r_pw - PW_ONE;
                if (w_stop_req) w_stop_nxt = 1'b1;
            end
            if (r_cnt != '0) begin
                w_cnt_nxt = r_cnt - ONE;
            end else if (!r_last && !r_stop_pend) begin
                w_step_nxt = 1'b1;
                w_pw_nxt   = PW_LOAD;
                w_rem_nxt  = w_rem_dec;
                if (w_rem_dec == '0) begin
                    w_last_nxt = 1'b1;
                end else if (r_state == S_ACCEL) begin
                    if (w_rem_dec <= r_ramp) begin
                        w_state_nxt = S_DECEL;
                        w_cur_nxt   = sat_add(r_cur, r_sh_accel, r_sh_start);
                    end else begin
                        w_cur_nxt  = sat_sub(r_cur, r_sh_accel, r_sh_end);
                        w_ramp_nxt = r_ramp + ONE;
                        if (w_cur_nxt == r_sh_end) w_state_nxt = S_CRUISE;
                    end
                end else if (r_state == S_CRUISE) begin
                    if (w_rem_dec <= r_ramp) begin
                        w_state_nxt = S_DECEL;
                        w_cur_nxt   = sat_add(r_cur, r_sh_accel, r_sh_start);
                    end
                end else begin
                    w_cur_nxt = sat_add(r_cur, r_sh_accel, r_sh_start);
                end
                w_cnt_nxt = w_cur_nxt - ONE;
            end
        end
    end

    always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
        if (rsi_MRST_reset) begin
            r_state     <= S_IDLE;
            r_cur       <= '0;
            r_ramp      <= '0;
            r_rem       <= '0;
            r_cnt       <= '0;
            r_pw        <= '0;
            r_step      <= 1'b0;
            r_dir       <= 1'b0;
            r_busy      <= 1'b0;
            r_last      <= 1'b0;
            r_stop_pend <= 1'b0;
            r_sh_start  <= '0;
            r_sh_end    <= '0;
            r_sh_accel  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cur       <= w_cur_nxt;
            r_ramp      <= w_ramp_nxt;
            r_rem       <= w_rem_nxt;
            r_cnt       <= w_cnt_nxt;
            r_pw        <= w_pw_nxt;
            r_step      <= w_step_nxt;
            r_dir       <= w_dir_nxt;
            r_busy      <= w_busy_nxt;
            r_last      <= w_last_nxt;
            r_stop_pend <= w_stop_nxt;
            if (w_load) begin
                r_sh_start <= w_eff_start;
                r_sh_end   <= w_eff_end;
                r_sh_accel <= w_accel_c;
            end
        end
    end

    always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
        if (rsi_MRST_reset) begin
            r_steps    <= '0;
            r_start_p  <= '0;
            r_end_p    <= '0;
            r_accel    <= '0;
            r_ctrl_dir <= 1'b0;
            r_irq_en   <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            if (avs_ctrl_write) begin
                case (avs_ctrl_address)
                    3'd0: r_steps   <= be_merge(r_steps,   avs_ctrl_writedata, avs_ctrl_byteenable);
                    3'd1: r_start_p <= be_merge(r_start_p, avs_ctrl_writedata, avs_ctrl_byteenable);
                    3'd2: r_end_p   <= be_merge(r_end_p,   avs_ctrl_writedata, avs_ctrl_byteenable);
                    3'd3: r_accel   <= be_merge(r_accel,   avs_ctrl_writedata, avs_ctrl_byteenable);
                    3'd4: if (avs_ctrl_byteenable[0]) begin
                        r_ctrl_dir <= avs_ctrl_writedata[0];
                        r_irq_en   <= avs_ctrl_writedata[3];
                    end
                    default: ;
                endcase
            end
            if (w_done_set)      r_done <= 1'b1;
            else if (w_done_clr) r_done <= 1'b0;
        end
    end

`ifdef STEP_RAMP_POSITION_EN
    logic signed [31:0] r_pos;
    logic               w_fire;
    assign w_fire = w_step_nxt && !r_step;

    always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
        if (rsi_MRST_reset)
            r_pos <= '0;
        else if (w_fire)
            r_pos <= r_dir ? (r_pos + 32'sd1) : (r_pos - 32'sd1);
        else if (avs_ctrl_write && (avs_ctrl_address == 3'd7) && !r_busy)
            r_pos <= $signed(be_merge(r_pos, avs_ctrl_writedata, avs_ctrl_byteenable));
    end
`endif

    logic [31:0] w_rdata;
    always_comb begin
        w_rdata = '0;
        case (avs_ctrl_address)
            3'd0: w_rdata = r_steps;
            3'd1: w_rdata = r_start_p;
            3'd2: w_rdata = r_end_p;
            3'd3: w_rdata = r_accel;
            3'd4: w_rdata = {28'd0, r_irq_en, 2'b00, r_ctrl_dir};
            3'd5: w_rdata = {30'd0, r_done, r_busy};
            3'd6: w_rdata = 32'(r_rem);
`ifdef STEP_RAMP_POSITION_EN
            3'd7: w_rdata = r_pos;
`else
            3'd7: w_rdata = '0;
`endif
            default: w_rdata = '0;
        endcase
    end

    always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
        if (rsi_MRST_reset)
            avs_ctrl_readdata <= '0;
        else if (avs_ctrl_read && !avs_ctrl_write)
            avs_ctrl_readdata <= w_rdata;
    end

    assign avs_ctrl_waitrequest = 1'b0;
    assign coe_step             = r_step;
    assign coe_dir              = r_dir;
    assign coe_busy             = r_busy;
    assign ins_irq              = r_done & r_irq_en;

endmodule

// File: tb/tb_step_ramp_generator.sv
// Directed bench for step_ramp_generator: register access, ramp timing, stop, reset.
`timescale 1ns/1ps
module tb_step_ramp_generator;

`ifdef STEP_RAMP_POSITION_EN
    localparam bit HAS_POS = 1'b1;
`else
    localparam bit HAS_POS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic [3:0]  be = '0;
    logic [2:0]  addr = '0;
    logic        wr = 1'b0, rd = 1'b0;
    logic        waitreq, step, dir, busy, irq;

    step_ramp_generator dut (
        .csi_MCLK_clk         (clk),
        .rsi_MRST_reset       (rst),
        .avs_ctrl_writedata   (wdata),
        .avs_ctrl_readdata    (rdata),
        .avs_ctrl_byteenable  (be),
        .avs_ctrl_address     (addr),
        .avs_ctrl_write       (wr),
        .avs_ctrl_read        (rd),
        .avs_ctrl_waitrequest (waitreq),
        .coe_step             (step),
        .coe_dir              (dir),
        .coe_busy             (busy),
        .ins_irq              (irq)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Edge monitor: records step rise cycles, pulse widths, busy transitions.
    int   rise_c[64];
    int   width_c[64];
    int   n_edges = 0;
    int   b_rise = 0, b_fall = 0, last_fall = 0;
    logic prev_step = 1'b0, prev_busy = 1'b0;
    always @(negedge clk) begin
        if (step && !prev_step && n_edges < 64) begin
            rise_c[n_edges] <= cyc;
            n_edges         <= n_edges + 1;
        end
        if (!step && prev_step && n_edges > 0) begin
            width_c[n_edges-1] <= cyc - rise_c[n_edges-1];
            last_fall          <= cyc;
        end
        if (busy && !prev_busy) b_rise <= cyc;
        if (!busy && prev_busy) b_fall <= cyc;
        prev_step <= step;
        prev_busy <= busy;
    end

    int exp_iv[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h (%0d) expected 0x%08h (%0d)", tag, got, got, exp, exp);
    endtask

    task automatic avs_wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] b);
        @(negedge clk);
        addr = a; wdata = d; be = b; wr = 1'b1;
        @(negedge clk);
        wr = 1'b0; be = '0;
    endtask

    task automatic avs_rd(input logic [2:0] a, output logic [31:0] d);
        @(negedge clk);
        addr = a; rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
        d = rdata;
    endtask

    task automatic wait_idle(input string tag, input int limit);
        int k;
        k = 0;
        while (busy && k < limit) begin
            @(negedge clk);
            k++;
        end
        check(tag, 32'(busy), 32'd0);
        @(negedge clk);
    endtask

    task automatic check_move(input string tag, input int base);
        int ref_c;
        check({tag, "_count"}, 32'(n_edges - base), 32'(exp_iv.size()));
        for (int i = 0; i < exp_iv.size(); i++) begin
            ref_c = (i == 0) ? b_rise : rise_c[base+i-1];
            check($sformatf("%s_iv%0d", tag, i), 32'(rise_c[base+i] - ref_c), 32'(exp_iv[i]));
            check($sformatf("%s_w%0d", tag, i), 32'(width_c[base+i]), 32'd16);
        end
        check({tag, "_done_at_fall"}, 32'(b_fall), 32'(last_fall));
    endtask

    task automatic set_profile(input int steps, input int sp, input int ep, input int ac);
        avs_wr(3'd0, 32'(steps), 4'hF);
        avs_wr(3'd1, 32'(sp), 4'hF);
        avs_wr(3'd2, 32'(ep), 4'hF);
        avs_wr(3'd3, 32'(ac), 4'hF);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rv;
        int          base;
        int          k;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_step",  32'(step), 32'd0);
        check("rst_busy",  32'(busy), 32'd0);
        check("rst_dir",   32'(dir),  32'd0);
        check("rst_irq",   32'(irq),  32'd0);
        check("rst_wait",  32'(waitreq), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        avs_rd(3'd5, rv);
        check("rst_status", rv, 32'd0);

        // Constant-speed move, forward.
        set_profile(5, 100, 100, 0);
        base = n_edges;
        avs_wr(3'd4, 32'h3, 4'h1);
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_dir",  32'(dir),  32'd1);
        wait_idle("t1_idle", 2000);
        exp_iv = '{100, 100, 100, 100, 100};
        check_move("t1", base);
        avs_rd(3'd5, rv); check("t1_status", rv, 32'h2);
        avs_rd(3'd4, rv); check("t1_ctrl_rb", rv, 32'h1);
        avs_rd(3'd7, rv); check("t1_pos", rv, HAS_POS ? 32'd5 : 32'd0);

        // Full trapezoid with interrupt enabled.
        avs_wr(3'd5, 32'h2, 4'h1);
        check("t2_irq_clr0", 32'(irq), 32'd0);
        set_profile(10, 400, 100, 100);
        base = n_edges;
        avs_wr(3'd4, 32'hB, 4'h1);
        wait_idle("t2_idle", 5000);
        exp_iv = '{400, 300, 200, 100, 100, 100, 100, 200, 300, 400};
        check_move("t2", base);
        avs_rd(3'd6, rv); check("t2_remaining", rv, 32'd0);
        check("t2_irq", 32'(irq), 32'd1);
        avs_wr(3'd5, 32'h2, 4'h1);
        check("t2_irq_clr", 32'(irq), 32'd0);
        avs_rd(3'd7, rv); check("t2_pos", rv, HAS_POS ? 32'd15 : 32'd0);

        // Short move decelerates before reaching cruise speed.
        avs_wr(3'd0, 32'd4, 4'hF);
        base = n_edges;
        avs_wr(3'd4, 32'h3, 4'h1);
        wait_idle("t3_idle", 3000);
        exp_iv = '{400, 300, 200, 300};
        check_move("t3", base);

        // Zero-step move: done next cycle, no pulse.
        avs_wr(3'd5, 32'h2, 4'h1);
        avs_wr(3'd0, 32'd0, 4'hF);
        base = n_edges;
        avs_wr(3'd4, 32'hA, 4'h1);
        check("t4_irq", 32'(irq), 32'd1);
        check("t4_busy", 32'(busy), 32'd0);
        repeat (200) @(negedge clk);
        check("t4_edges", 32'(n_edges - base), 32'd0);
        avs_wr(3'd5, 32'h2, 4'h1);

        // Start while busy is ignored; register change applies to the next move only.
        set_profile(5, 100, 100, 0);
        base = n_edges;
        avs_wr(3'd4, 32'h3, 4'h1);
        repeat (250) @(negedge clk);
        avs_wr(3'd0, 32'd20, 4'hF);
        avs_wr(3'd4, 32'h3, 4'h1);
        wait_idle("t4b_idle", 2000);
        exp_iv = '{100, 100, 100, 100, 100};
        check_move("t4b", base);
        avs_rd(3'd0, rv); check("t4b_steps_rb", rv, 32'd20);
        avs_rd(3'd7, rv); check("t4b_pos", rv, HAS_POS ? 32'd24 : 32'd0);

        // Stop mid-pulse, reverse direction.
        avs_wr(3'd7, 32'd0, 4'hF);
        set_profile(10, 400, 100, 100);
        base = n_edges;
        avs_wr(3'd4, 32'h2, 4'h1);
        check("t5_dir", 32'(dir), 32'd0);
        avs_wr(3'd7, 32'd100, 4'hF);
        k = 0;
        while ((n_edges - base) < 3 && k < 3000) begin
            @(negedge clk);
            k++;
        end
        check("t5_third_edge", 32'((n_edges - base) >= 3), 32'd1);
        repeat (5) @(negedge clk);
        avs_wr(3'd4, 32'h4, 4'h1);
        check("t5_step_held", 32'(step), 32'd1);
        wait_idle("t5_idle", 200);
        repeat (600) @(negedge clk);
        exp_iv = '{400, 300, 200};
        check_move("t5", base);
        avs_rd(3'd6, rv); check("t5_remaining", rv, 32'd7);
        avs_rd(3'd5, rv); check("t5_status", rv, 32'h2);
        avs_rd(3'd7, rv); check("t5_pos", rv, HAS_POS ? 32'hFFFF_FFFD : 32'd0);

        // Byte-lane write.
        avs_wr(3'd0, 32'd0, 4'hF);
        avs_wr(3'd0, 32'hAABB_CCDD, 4'b0010);
        avs_rd(3'd0, rv); check("t6_be", rv, 32'h0000_CC00);

        // Asynchronous reset during a pulse.
        set_profile(5, 100, 100, 0);
        avs_wr(3'd4, 32'h3, 4'h1);
        k = 0;
        while (!step && k < 300) begin
            @(negedge clk);
            k++;
        end
        check("t7_step_seen", 32'(step), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("t7_step_async", 32'(step), 32'd0);
        check("t7_busy_async", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        avs_rd(3'd0, rv); check("t7_steps", rv, 32'd0);
        avs_rd(3'd5, rv); check("t7_status", rv, 32'd0);
        avs_rd(3'd6, rv); check("t7_remaining", rv, 32'd0);
        avs_rd(3'd7, rv); check("t7_pos", rv, 32'd0);
        check("t7_dir", 32'(dir), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
